// File: rtl/dma_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_pkg : shared types and defaults for the DMA channel scheduler  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dma_pkg;

  localparam int ADDR_W_DEFAULT      = 32;
  localparam int DMA_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_rr_arbiter : combinational round-robin pick from a pointer     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         eligible_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [$clog2(NUM_CH)-1:0] grant_idx_o,
  output logic                      valid_o
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] w_rot;
  logic [CH_W-1:0]   w_off;
  logic [CH_W:0]     w_sum;

  // Rotate so bit 0 is the channel at the pointer; lowest set bit wins.
  assign w_rot = NUM_CH'({eligible_i, eligible_i} >> ptr_i);

  always_comb begin
    w_off   = '0;
    valid_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = CH_W'(i);
        valid_o = 1'b1;
      end
    end
  end

  assign w_sum       = {1'b0, ptr_i} + {1'b0, w_off};
  assign grant_idx_o = (w_sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(w_sum - (CH_W+1)'(NUM_CH))
                                                    : CH_W'(w_sum);

endmodule
`default_nettype wire

// File: rtl/dma_channel_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_channel_scheduler : shares one DMA engine between NUM_CH chans |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dma_channel_scheduler
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int TIMEOUT_CYC = DMA_TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_src,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_dst,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_size,
  output logic [NUM_CH-1:0]          ch_grant,
  output logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH-1:0]          ch_err,
  output logic                       busy,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       dma_start,
  input  logic                       dma_done,
  output logic [ADDR_W-1:0]          source_addr,
  output logic [ADDR_W-1:0]          dest_addr,
  output logic [ADDR_W-1:0]          transfer_size
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  sched_state_t      state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              busy_q, busy_d;
  logic [CH_W-1:0]   active_q, active_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              start_q, start_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] size_q, size_d;

  logic [ADDR_W-1:0] w_src  [NUM_CH];
  logic [ADDR_W-1:0] w_dst  [NUM_CH];
  logic [ADDR_W-1:0] w_size [NUM_CH];
  logic [CH_W-1:0]   w_arb_idx;
  logic              w_arb_valid;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign w_src[gi]  = ch_src[gi*ADDR_W +: ADDR_W];
    assign w_dst[gi]  = ch_dst[gi*ADDR_W +: ADDR_W];
    assign w_size[gi] = ch_size[gi*ADDR_W +: ADDR_W];
  end

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .eligible_i  (ch_req & ch_enable),
    .ptr_i       (ptr_q),
    .grant_idx_o (w_arb_idx),
    .valid_o     (w_arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = '0;
    busy_d   = busy_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    start_d  = start_q;
    wd_d     = wd_q;
    src_d    = src_q;
    dst_d    = dst_q;
    size_d   = size_q;
    unique case (state_q)
      IDLE: begin
        if (w_arb_valid) begin
          grant_d  = NUM_CH'(1) << w_arb_idx;
          active_d = w_arb_idx;
          busy_d   = 1'b1;
          src_d    = w_src[w_arb_idx];
          dst_d    = w_dst[w_arb_idx];
          size_d   = w_size[w_arb_idx];
          // Zero-length transfers complete without touching the engine.
          state_d  = (w_size[w_arb_idx] == '0) ? DONE : START;
        end
      end
      START: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (dma_done) begin
          start_d = 1'b0;
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          start_d = 1'b0;
          state_d = ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE, ERR: begin
        if (state_q == DONE) done_d = grant_q;
        else                 err_d  = grant_q;
        grant_d  = '0;
        busy_d   = 1'b0;
        active_d = '0;
        // Advance past the finishing channel even on error so a hung one cannot starve the rest.
        ptr_d    = (active_q == CH_W'(NUM_CH - 1)) ? '0 : active_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      active_q <= '0;
      ptr_q    <= '0;
      start_q  <= 1'b0;
      wd_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      start_q  <= start_d;
      wd_q     <= wd_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      size_q   <= size_d;
    end
  end

  assign ch_grant      = grant_q;
  assign ch_done       = done_q;
  assign ch_err        = err_q;
  assign busy          = busy_q;
  assign active_ch     = active_q;
  assign dma_start     = start_q;
  assign source_addr   = src_q;
  assign dest_addr     = dst_q;
  assign transfer_size = size_q;

endmodule
`default_nettype wire

// File: doc/dma_channel_scheduler.md
Name: dma_channel_scheduler

Overview:
- Shares one basic DMA engine (start/done handshake, source/dest/size configuration) between NUM_CH requesting channels.
- Arbitrates round-robin and latches the winner's transfer descriptor.
- Drives the engine's configuration and start, waits for done with a watchdog, then reports completion or error to the channel.
- Sits between peripheral/CPU request logic and the DMA engine; same clock and reset as the engine.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- ADDR_W, 32, address and size width
- TIMEOUT_CYC, 1024, max cycles from dma_start to dma_done before abort

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ch_req  in  NUM_CH  level request per channel
- ch_enable  in  NUM_CH  channel mask; a disabled channel is never granted
- ch_src  in  NUM_CH*ADDR_W  source address per channel; channel i at bits [i*ADDR_W +: ADDR_W]
- ch_dst  in  NUM_CH*ADDR_W  destination address per channel, same packing
- ch_size  in  NUM_CH*ADDR_W  transfer size per channel, same packing
- ch_grant  out  NUM_CH  one-hot; high while the channel owns the engine
- ch_done  out  NUM_CH  one-cycle completion pulse
- ch_err  out  NUM_CH  one-cycle timeout pulse
- busy  out  1  high in any state other than IDLE
- active_ch  out  clog2(NUM_CH)  index of the granted channel; 0 when idle
- dma_start  out  1  start to the engine
- dma_done  in  1  engine completion level
- source_addr  out  ADDR_W  latched source address to the engine
- dest_addr  out  ADDR_W  latched destination address to the engine
- transfer_size  out  ADDR_W  latched transfer size to the engine

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is 0, so channel 0 has first priority.
  - Watchdog count is 0.
- States: IDLE, START, WAIT, DONE, ERR.
- IDLE:
  - Eligible set is ch_req & ch_enable.
  - If non-empty, pick the first eligible index at or after the pointer, wrapping modulo NUM_CH.
  - Latch that channel's src/dst/size into source_addr/dest_addr/transfer_size.
  - Set ch_grant one-hot, set active_ch, raise busy.
  - If the latched size is 0, go to DONE without starting the engine; otherwise go to START.
- START:
  - dma_start goes high (registered) and the watchdog clears.
  - Go to WAIT.
- WAIT:
  - dma_start stays high and the watchdog increments each cycle.
  - When dma_done=1 is sampled, clear dma_start and go to DONE.
  - If the watchdog reaches TIMEOUT_CYC-1 with no done, clear dma_start and go to ERR.
  - If dma_done and the timeout occur in the same cycle, done wins.
- DONE:
  - Pulse ch_done[active_ch] for exactly one cycle.
  - Drop ch_grant and busy.
  - Set pointer to (active_ch+1) mod NUM_CH.
  - Go to IDLE.
- ERR:
  - Same as DONE, but pulse ch_err instead of ch_done.
- Latency:
  - Request sampled in IDLE at cycle N gives ch_grant at N+1 and dma_start at N+2.
  - At least one IDLE cycle separates consecutive grants.
- Descriptor latching:
  - Descriptors are sampled only at grant; later changes to ch_src/dst/size are ignored until the next grant.
- Request handling:
  - ch_req is level-sensitive. A requester that keeps req high after its ch_done pulse is re-arbitrated and receives another transfer.
  - Round-robin guarantees other eligible channels are served first.
- Dropped request or disable:
  - Dropping ch_req or ch_enable after grant does not abort the transfer.
- Outputs stable during a transfer:
  - source_addr, dest_addr and transfer_size hold from grant until the next grant.
  - They are not cleared on DONE.
- Reset mid-transfer:
  - Immediate return to IDLE with all outputs 0.
  - No ch_done or ch_err pulse.
  - The engine is reset by the same reset.
- Pointer on error:
  - The pointer advances after ERR exactly as after DONE, so a hung channel cannot starve the others.

Decomposition:
- Package dma_pkg holds:
  - the sched_state_t enum (IDLE, START, WAIT, DONE, ERR)
  - ADDR_W default
  - DMA_TIMEOUT_DEFAULT
- One sub-module, dma_rr_arbiter:
  - Inputs: eligible vector and pointer.
  - Outputs: grant index and a valid flag.
  - Purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Single channel:
  - Stimulus: ch_req=0001, ch_src0=0x50, dst0=0x100, size0=0x11; engine model asserts done 17 cycles after start.
  - Required: grant=0001 one cycle after req; dma_start one cycle later with source_addr=0x50, dest_addr=0x100, transfer_size=0x11; single ch_done[0] pulse; busy low after.
- Contention:
  - Stimulus: ch_req=1111 held high.
  - Required: grant order 0,1,2,3,0; each grant separated by at least one IDLE cycle.
- Masking:
  - Stimulus: ch_req=0110, ch_enable=0100.
  - Required: only channel 2 granted; channel 1 never granted.
- Zero size:
  - Stimulus: size=0 on channel 3.
  - Required: ch_done[3] pulse two cycles after req; dma_start never asserted.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, engine never asserts done.
  - Required: ch_err pulse; dma_start deasserted; pointer advances to the next channel.
- Reset mid-WAIT:
  - Stimulus: reset=1 for one cycle while in WAIT.
  - Required: all outputs 0 the next cycle; no done or err pulse; channel 0 has priority again.
